// File: rtl/fifo_ctrl_fsm.sv
// Read/write control FSM for the FSM-based FIFO: RAM enables, pointers, occupancy and raw flags.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module fifo_ctrl_fsm #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  Clear,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  in_full,
  output logic                  in_empty,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_NEARLY = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, NORMAL = 2'd1, FULL = 2'd2} state_t;
  state_t state;

  // Acceptance is zero-latency so the RAM sees enables in the request cycle.
  assign wr_en = wr_req & (state != FULL);
  assign rd_en = rd_req & (state != EMPTY);

  always_ff @(posedge clk) begin
    if (Clear) begin
      state    <= EMPTY;
      wr_addr  <= '0;
      rd_addr  <= '0;
      count    <= '0;
      in_full  <= 1'b0;
      in_empty <= 1'b1;
    end else begin
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      if (wr_en & ~rd_en)      count <= count + 1'b1;
      else if (rd_en & ~wr_en) count <= count - 1'b1;
      // Flags are updated alongside the state so they stay pure flop outputs.
      case (state)
        EMPTY: if (wr_en) begin
          state    <= NORMAL;
          in_empty <= 1'b0;
        end
        NORMAL: begin
          if (wr_en & ~rd_en & (count == CNT_NEARLY)) begin
            state   <= FULL;
            in_full <= 1'b1;
          end else if (rd_en & ~wr_en & (count == CNT_ONE)) begin
            state    <= EMPTY;
            in_empty <= 1'b1;
          end
        end
        FULL: if (rd_en) begin
          state   <= NORMAL;
          in_full <= 1'b0;
        end
        default: begin
          state    <= EMPTY;
          in_full  <= 1'b0;
          in_empty <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (Clear) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if ((state == FULL) & wr_req & ~rd_req) ovf_err <= 1'b1;
      if ((state == EMPTY) & rd_req)          udf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Directed bench for fifo_ctrl_fsm: an occupancy model pushes expected post-edge state to a queue.
module tb_fifo_ctrl_fsm;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic Clear, wr_req, rd_req;
  logic wr_en, rd_en, in_full, in_empty, ovf_err, udf_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0] count;

  always #5 clk = ~clk;

  fifo_ctrl_fsm #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .Clear(Clear), .wr_req(wr_req), .rd_req(rd_req),
    .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .count(count), .in_full(in_full), .in_empty(in_empty),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  typedef struct {
    int wa, ra, cnt;
    logic full, empty, ovf, udf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model state
  int m_wa = 0, m_ra = 0, m_cnt = 0;
  logic m_ovf = 1'b0, m_udf = 1'b0;
  bit err_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c);
    logic m_full, m_empty, acc_w, acc_r;
    exp_t e, got;
    Clear = c; wr_req = w; rd_req = r;
    #1;
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    acc_w = w & ~m_full;
    acc_r = r & ~m_empty;
    chk("wr_en", 32'(wr_en), 32'(acc_w));
    chk("rd_en", 32'(rd_en), 32'(acc_r));
    if (c) begin
      m_wa = 0; m_ra = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (err_en && m_full && w && !r) m_ovf = 1'b1;
      if (err_en && m_empty && r) m_udf = 1'b1;
      if (acc_w) m_wa = (m_wa + 1) % DEPTH;
      if (acc_r) m_ra = (m_ra + 1) % DEPTH;
      if (acc_w && !acc_r) m_cnt++;
      else if (acc_r && !acc_w) m_cnt--;
    end
    e.wa = m_wa; e.ra = m_ra; e.cnt = m_cnt;
    e.full = (m_cnt == DEPTH); e.empty = (m_cnt == 0);
    e.ovf = m_ovf; e.udf = m_udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("wr_addr", 32'(wr_addr), 32'(got.wa));
    chk("rd_addr", 32'(rd_addr), 32'(got.ra));
    chk("count", 32'(count), 32'(got.cnt));
    chk("in_full", 32'(in_full), 32'(got.full));
    chk("in_empty", 32'(in_empty), 32'(got.empty));
    chk("ovf_err", 32'(ovf_err), 32'(got.ovf));
    chk("udf_err", 32'(udf_err), 32'(got.udf));
  endtask

  initial begin
`ifdef FIFO_CTRL_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    Clear = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    // Reset, then idle
    step(0, 0, 1);
    step(0, 0, 0);
    // Fill: 16 writes, wr_addr wraps; 17th write rejected (overflow if built)
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    chk("full_after_16", 32'(in_full), 32'd1);
    chk("count_16", 32'(count), 32'd16);
    step(1, 0, 0);
    // Drain: 16 reads, 17th rejected (underflow if built)
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    chk("empty_after_16", 32'(in_empty), 32'd1);
    step(0, 1, 0);
    // Clear drops sticky flags
    step(0, 0, 1);
    // EMPTY with both requests: write only
    step(1, 1, 0);
    chk("count_1", 32'(count), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    // NORMAL, count 5, both accepted for 20 cycles
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    chk("count_5", 32'(count), 32'd5);
    // Fill to FULL, then both requests: read only
    for (int i = 0; i < 11; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("count_15", 32'(count), 32'd15);
    // Down to 9, then Clear with requests active
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("count_9", 32'(count), 32'd9);
    step(1, 1, 1);
    step(0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
